// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle for rv32i_mem_arbiter: fetch port, load/store port and shared memory port.
// Handshake: a requester raises stb with a stable payload and holds both until its one-cycle ack.
interface rv32i_mem_arbiter_if;
   logic        i_stb_inst;
   logic [31:0] i_iaddr;
   logic        o_ack_inst;
   logic [31:0] o_inst;

   logic        i_stb_data;
   logic        i_we_data;
   logic [31:0] i_daddr;
   logic [31:0] i_wdata;
   logic [3:0]  i_wsel;
   logic        o_ack_data;
   logic [31:0] o_rdata;
   logic        o_err;

   logic        o_mem_stb;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_sel;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   // master is the arbiter itself; slave is the surrounding core and memory.
   modport master (
      input  i_stb_inst, i_iaddr, i_stb_data, i_we_data, i_daddr, i_wdata, i_wsel,
      input  i_mem_ack, i_mem_rdata,
      output o_ack_inst, o_inst, o_ack_data, o_rdata, o_err,
      output o_mem_stb, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel
   );

   modport slave (
      output i_stb_inst, i_iaddr, i_stb_data, i_we_data, i_daddr, i_wdata, i_wsel,
      output i_mem_ack, i_mem_rdata,
      input  o_ack_inst, o_inst, o_ack_data, o_rdata, o_err,
      input  o_mem_stb, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel
   );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data to single memory bus arbiter with data priority and registered responses.
// Optional BUSY timeout abort is enabled by defining RV32I_ARB_TIMEOUT_EN.
module rv32i_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   rv32i_mem_arbiter_if.master  bus,
   output logic [1:0]           dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("rv32i_mem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
   end

   logic [1:0] state;
   logic       owner_data;
   logic       resp_now;
   logic       resp_err;

`ifdef RV32I_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt;

   // A real ack always beats a coinciding timeout.
   always_comb begin
      resp_now = bus.i_mem_ack;
      resp_err = 1'b0;
      if (!bus.i_mem_ack && tmo_cnt == TMO_LAST) begin
         resp_now = 1'b1;
         resp_err = 1'b1;
      end
   end
`else
   always_comb begin
      resp_now = bus.i_mem_ack;
      resp_err = 1'b0;
   end
`endif

   assign dbg_state = state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= ST_IDLE;
         owner_data      <= 1'b0;
         bus.o_mem_stb   <= 1'b0;
         bus.o_mem_we    <= 1'b0;
         bus.o_mem_addr  <= 32'h0;
         bus.o_mem_wdata <= 32'h0;
         bus.o_mem_sel   <= 4'h0;
         bus.o_ack_inst  <= 1'b0;
         bus.o_ack_data  <= 1'b0;
         bus.o_inst      <= 32'h0;
         bus.o_rdata     <= 32'h0;
         bus.o_err       <= 1'b0;
`ifdef RV32I_ARB_TIMEOUT_EN
         tmo_cnt         <= 16'h0;
`endif
      end else begin
         bus.o_ack_inst <= 1'b0;
         bus.o_ack_data <= 1'b0;
         case (state)
            ST_IDLE: begin
`ifdef RV32I_ARB_TIMEOUT_EN
               tmo_cnt <= 16'h0;
`endif
               if (bus.i_stb_data) begin
                  owner_data      <= 1'b1;
                  bus.o_mem_we    <= bus.i_we_data;
                  bus.o_mem_addr  <= bus.i_daddr;
                  bus.o_mem_wdata <= bus.i_wdata;
                  bus.o_mem_sel   <= bus.i_wsel;
                  bus.o_mem_stb   <= 1'b1;
                  state           <= ST_BUSY;
               end else if (bus.i_stb_inst) begin
                  owner_data      <= 1'b0;
                  bus.o_mem_we    <= 1'b0;
                  bus.o_mem_addr  <= bus.i_iaddr;
                  bus.o_mem_wdata <= 32'h0;
                  bus.o_mem_sel   <= 4'hF;
                  bus.o_mem_stb   <= 1'b1;
                  state           <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (resp_now) begin
                  bus.o_mem_stb <= 1'b0;
                  bus.o_err     <= resp_err;
                  state         <= ST_RESP;
                  if (owner_data) begin
                     bus.o_ack_data <= 1'b1;
                     bus.o_rdata    <= resp_err ? 32'h0 : bus.i_mem_rdata;
                  end else begin
                     bus.o_ack_inst <= 1'b1;
                     bus.o_inst     <= resp_err ? 32'h0 : bus.i_mem_rdata;
                  end
               end
`ifdef RV32I_ARB_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            ST_RESP: begin
               // Any stb still high here belongs to the request just completed.
               bus.o_err <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: scenario tasks with a response scoreboard.
module tb_rv32i_mem_arbiter;

   localparam logic [1:0] ST_IDLE = 2'd0;

   logic        clk;
   logic        rst_n;
   logic [1:0]  dbg_state;
   int          vectors = 0;
   int          miscompares = 0;
   logic [32:0] exp_q[$];

   rv32i_mem_arbiter_if bus();

   rv32i_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      bus.i_stb_inst  = 1'b0;
      bus.i_iaddr     = 32'h0;
      bus.i_stb_data  = 1'b0;
      bus.i_we_data   = 1'b0;
      bus.i_daddr     = 32'h0;
      bus.i_wdata     = 32'h0;
      bus.i_wsel      = 4'h0;
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = 32'h0;
   endtask

   // Memory responder: waits for o_mem_stb, holds ack low for lat cycles, then acks once.
   // Returns at the negedge where the requester ack should be visible.
   task automatic mem_respond(input int lat, input logic [31:0] rdata, input bit wiggle,
                              output bit found, output int wait_cyc, output int stb_cyc,
                              output bit stable, output logic seen_we,
                              output logic [31:0] seen_addr, output logic [31:0] seen_wdata,
                              output logic [3:0] seen_sel);
      found = 1'b0; wait_cyc = 0; stb_cyc = 0; stable = 1'b1;
      seen_we = 1'b0; seen_addr = 32'h0; seen_wdata = 32'h0; seen_sel = 4'h0;
      while (!found && wait_cyc < 16) begin
         @(negedge clk);
         wait_cyc++;
         found = bus.o_mem_stb;
      end
      if (!found) return;
      seen_we = bus.o_mem_we; seen_addr = bus.o_mem_addr;
      seen_wdata = bus.o_mem_wdata; seen_sel = bus.o_mem_sel;
      stb_cyc = 1;
      for (int i = 0; i < lat; i++) begin
         if (wiggle) begin
            bus.i_iaddr = $urandom; bus.i_daddr = $urandom; bus.i_wdata = $urandom;
         end
         @(negedge clk);
         if (bus.o_mem_stb) stb_cyc++;
         if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_sel} !==
             {seen_we, seen_addr, seen_wdata, seen_sel}) stable = 1'b0;
      end
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = rdata;
      @(negedge clk);
      bus.i_mem_ack = 1'b0;
      bus.i_mem_rdata = $urandom;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.o_mem_stb, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_sel,
           bus.o_ack_inst, bus.o_ack_data, bus.o_inst, bus.o_rdata, bus.o_err} !== 137'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: stb=%b ack_i=%b ack_d=%b addr=%h, required all zero",
                  bus.o_mem_stb, bus.o_ack_inst, bus.o_ack_data, bus.o_mem_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (dbg_state !== ST_IDLE || bus.o_mem_stb !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: state=%0d stb=%b, required 0 0", dbg_state, bus.o_mem_stb);
      end
   endtask

   task automatic test_fetch();
      bit found, stable; int w, s; logic we; logic [31:0] a, wd, obs_d; logic [3:0] sel;
      logic [32:0] exp;
      bus.i_stb_inst = 1'b1; bus.i_iaddr = 32'h10;
      exp_q.push_back({1'b0, 32'h00100093});
      mem_respond(0, 32'h00100093, 1'b0, found, w, s, stable, we, a, wd, sel);
      vectors++;
      if (!found || w != 1 || s != 1) begin
         miscompares++;
         $display("FAIL fetch_timing: found=%b wait=%0d stb_cycles=%0d, required 1 1 1", found, w, s);
      end
      vectors++;
      if ({we, a, sel} !== {1'b0, 32'h10, 4'hF}) begin
         miscompares++;
         $display("FAIL fetch_bus: we=%b addr=%h sel=%h, required 0 00000010 f", we, a, sel);
      end
      vectors++;
      if ({bus.o_ack_inst, bus.o_ack_data, bus.o_err, bus.o_mem_stb} !== 4'b1000) begin
         miscompares++;
         $display("FAIL fetch_ack: ack_i/ack_d/err/stb=%b, required 1000",
                  {bus.o_ack_inst, bus.o_ack_data, bus.o_err, bus.o_mem_stb});
      end
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if ({bus.o_ack_data, obs_d} !== exp) begin
         miscompares++;
         $display("FAIL fetch_sb: got %h, required %h", {bus.o_ack_data, obs_d}, exp);
      end
      bus.i_stb_inst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.o_ack_inst, bus.o_ack_data} !== 2'b00 || dbg_state !== ST_IDLE) begin
         miscompares++;
         $display("FAIL fetch_one_cycle: acks=%b state=%0d, required 00 0",
                  {bus.o_ack_inst, bus.o_ack_data}, dbg_state);
      end
   endtask

   task automatic test_priority();
      bit found, stable; int w, s; logic we; logic [31:0] a, wd, obs_d, rd1, rd2;
      logic [3:0] sel; logic [32:0] exp;
      rd1 = $urandom; rd2 = $urandom;
      bus.i_stb_inst = 1'b1; bus.i_iaddr = 32'h20;
      bus.i_stb_data = 1'b1; bus.i_we_data = 1'b1; bus.i_daddr = 32'h100;
      bus.i_wdata = 32'hDEADBEEF; bus.i_wsel = 4'h3;
      exp_q.push_back({1'b1, rd1});
      exp_q.push_back({1'b0, rd2});
      mem_respond(1, rd1, 1'b0, found, w, s, stable, we, a, wd, sel);
      vectors++;
      if ({found, we, a, wd, sel} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3}) begin
         miscompares++;
         $display("FAIL prio_store_bus: found=%b we=%b addr=%h wdata=%h sel=%h, required 1 1 100 deadbeef 3",
                  found, we, a, wd, sel);
      end
      vectors++;
      if ({bus.o_ack_inst, bus.o_ack_data} !== 2'b01) begin
         miscompares++;
         $display("FAIL prio_store_ack: acks=%b, required 01", {bus.o_ack_inst, bus.o_ack_data});
      end
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if ({bus.o_ack_data, obs_d} !== exp) begin
         miscompares++;
         $display("FAIL prio_store_sb: got %h, required %h", {bus.o_ack_data, obs_d}, exp);
      end
      bus.i_stb_data = 1'b0; bus.i_we_data = 1'b0;
      mem_respond(0, rd2, 1'b0, found, w, s, stable, we, a, wd, sel);
      vectors++;
      if ({found, we, a, sel} !== {1'b1, 1'b0, 32'h20, 4'hF} || w != 2) begin
         miscompares++;
         $display("FAIL prio_fetch_bus: found=%b wait=%0d we=%b addr=%h sel=%h, required 1 2 0 20 f",
                  found, w, we, a, sel);
      end
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if ({bus.o_ack_inst, bus.o_ack_data, obs_d} !== {1'b1, exp}) begin
         miscompares++;
         $display("FAIL prio_fetch_sb: ack_i=%b got %h, required 1 %h",
                  bus.o_ack_inst, {bus.o_ack_data, obs_d}, exp);
      end
      bus.i_stb_inst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wait_states();
      bit found, stable; int w, s; logic we; logic [31:0] a, wd, obs_d, rd;
      logic [3:0] sel; logic [32:0] exp;
      rd = $urandom;
      bus.i_stb_data = 1'b1; bus.i_we_data = 1'b0; bus.i_daddr = 32'h40; bus.i_wsel = 4'hF;
      exp_q.push_back({1'b1, rd});
      mem_respond(5, rd, 1'b1, found, w, s, stable, we, a, wd, sel);
      vectors++;
      if (!found || s != 6 || !stable || a !== 32'h40 || we !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_bus: found=%b stb_cycles=%0d stable=%b addr=%h we=%b, required 1 6 1 40 0",
                  found, s, stable, a, we);
      end
      vectors++;
      if ({bus.o_ack_inst, bus.o_ack_data, bus.o_mem_stb} !== 3'b010) begin
         miscompares++;
         $display("FAIL wait_ack: ack_i/ack_d/stb=%b, required 010",
                  {bus.o_ack_inst, bus.o_ack_data, bus.o_mem_stb});
      end
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if ({bus.o_ack_data, obs_d} !== exp) begin
         miscompares++;
         $display("FAIL wait_sb: got %h, required %h", {bus.o_ack_data, obs_d}, exp);
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_mem_ack_idle();
      bit bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.i_mem_ack = 1'b1; bus.i_mem_rdata = $urandom;
         @(negedge clk);
         if (bus.o_ack_inst || bus.o_ack_data || bus.o_mem_stb || dbg_state !== ST_IDLE) bad = 1'b1;
      end
      bus.i_mem_ack = 1'b0;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL idle_mem_ack: stray ack or stb seen, required none");
      end
   endtask

   task automatic test_back_to_back();
      bit found, stable; int w, s; logic we; logic [31:0] a, wd, obs_d, rd, addr;
      logic [3:0] sel; logic [32:0] exp; bit is_data; int lat;
      for (int n = 0; n < 10; n++) begin
         is_data = 1'($urandom_range(0, 1));
         lat = $urandom_range(0, 3);
         rd = $urandom;
         addr = $urandom & 32'hFFFF_FFFC;
         bus.i_stb_inst = !is_data; bus.i_iaddr = addr;
         bus.i_stb_data = is_data; bus.i_daddr = addr; bus.i_we_data = 1'($urandom_range(0, 1));
         bus.i_wdata = $urandom; bus.i_wsel = 4'($urandom_range(1, 15));
         exp_q.push_back({is_data, rd});
         mem_respond(lat, rd, 1'b0, found, w, s, stable, we, a, wd, sel);
         vectors++;
         if (!found || a !== addr || s != lat + 1 || (!is_data && sel !== 4'hF)) begin
            miscompares++;
            $display("FAIL b2b_bus[%0d]: found=%b addr=%h stb_cycles=%0d sel=%h, required 1 %h %0d",
                     n, found, a, s, sel, addr, lat + 1);
         end
         obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
         exp = exp_q.pop_front();
         vectors++;
         if ({bus.o_ack_inst ^ bus.o_ack_data, bus.o_err, bus.o_ack_data, obs_d} !== {2'b10, exp}) begin
            miscompares++;
            $display("FAIL b2b_sb[%0d]: acks=%b err=%b got %h, required one ack, err 0, %h",
                     n, {bus.o_ack_inst, bus.o_ack_data}, bus.o_err, {bus.o_ack_data, obs_d}, exp);
         end
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      bit found, stable; int w, s; logic we; logic [31:0] a, wd, obs_d, rd;
      logic [3:0] sel; logic [32:0] exp;
      bus.i_stb_inst = 1'b1; bus.i_iaddr = 32'h80;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.o_mem_stb, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_sel,
           bus.o_ack_inst, bus.o_ack_data, bus.o_inst, bus.o_rdata, bus.o_err} !== 137'h0 ||
          dbg_state !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_busy: stb=%b addr=%h inst=%h rdata=%h state=%0d, required all zero",
                  bus.o_mem_stb, bus.o_mem_addr, bus.o_inst, bus.o_rdata, dbg_state);
      end
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      rd = $urandom;
      bus.i_stb_inst = 1'b1; bus.i_iaddr = 32'h84;
      exp_q.push_back({1'b0, rd});
      mem_respond(1, rd, 1'b0, found, w, s, stable, we, a, wd, sel);
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if (!found || w != 1 || a !== 32'h84 || {bus.o_ack_inst, bus.o_ack_data, obs_d} !== {1'b1, exp}) begin
         miscompares++;
         $display("FAIL reset_recover: found=%b wait=%0d addr=%h ack_i=%b got %h, required 1 1 84 1 %h",
                  found, w, a, bus.o_ack_inst, {bus.o_ack_data, obs_d}, exp);
      end
      drive_idle();
      @(negedge clk);
   endtask

`ifdef RV32I_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit found, stable; int w, s; logic we; logic [31:0] a, wd, obs_d, rd;
      logic [3:0] sel; logic [32:0] exp; int cnt;
      bus.i_stb_inst = 1'b1; bus.i_iaddr = 32'h90;
      exp_q.push_back({1'b0, 32'h0});
      cnt = 0;
      for (int i = 0; i < 20 && cnt == 0; i++) begin
         @(negedge clk);
         if (bus.o_mem_stb) cnt = 1;
      end
      for (int i = 0; i < 20 && bus.o_mem_stb; i++) begin
         @(negedge clk);
         if (bus.o_mem_stb) cnt++;
      end
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if (cnt != 4 || {bus.o_ack_inst, bus.o_err, bus.o_ack_data, obs_d} !== {2'b11, exp}) begin
         miscompares++;
         $display("FAIL timeout_abort: stb_cycles=%0d ack_i=%b err=%b got %h, required 4 1 1 %h",
                  cnt, bus.o_ack_inst, bus.o_err, {bus.o_ack_data, obs_d}, exp);
      end
      bus.i_stb_inst = 1'b0;
      @(negedge clk);
      rd = $urandom;
      bus.i_stb_inst = 1'b1; bus.i_iaddr = 32'h94;
      exp_q.push_back({1'b0, rd});
      mem_respond(3, rd, 1'b0, found, w, s, stable, we, a, wd, sel);
      obs_d = bus.o_ack_data ? bus.o_rdata : bus.o_inst;
      exp = exp_q.pop_front();
      vectors++;
      if (!found || s != 4 || {bus.o_ack_inst, bus.o_err, bus.o_ack_data, obs_d} !== {2'b10, exp}) begin
         miscompares++;
         $display("FAIL timeout_ack_wins: stb_cycles=%0d ack_i=%b err=%b got %h, required 4 1 0 %h",
                  s, bus.o_ack_inst, bus.o_err, {bus.o_ack_data, obs_d}, exp);
      end
      drive_idle();
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_wait_states();
      test_mem_ack_idle();
      test_back_to_back();
      test_reset_mid_busy();
`ifdef RV32I_ARB_TIMEOUT_EN
      test_timeout();
`endif
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Two-port to one-port memory arbiter for the rv32i core. It shares a single Wishbone-style memory bus between the instruction fetch port (stb/ack, as driven by the fetch stage) and the load/store data port. A small FSM grants one requester at a time, with data priority, and returns each response to its owner with registered data.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum BUSY cycles without `i_mem_ack` before the transaction is aborted. Used only with `RV32I_ARB_TIMEOUT_EN`; legal range 2..65535.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stb_inst`  in  1  fetch request; held until `o_ack_inst`.
- `i_iaddr`  in  32  fetch address, word aligned.
- `o_ack_inst`  out  1  one-cycle fetch completion.
- `o_inst`  out  32  fetched word, valid with `o_ack_inst`.
- `i_stb_data`  in  1  load/store request; held until `o_ack_data`.
- `i_we_data`  in  1  1 = store, 0 = load.
- `i_daddr`  in  32  data address.
- `i_wdata`  in  32  store data.
- `i_wsel`  in  4  byte enables.
- `o_ack_data`  out  1  one-cycle data completion.
- `o_rdata`  out  32  load data, valid with `o_ack_data`.
- `o_err`  out  1  response was a timeout abort; valid with either ack.
- `o_mem_stb`  out  1  memory request.
- `o_mem_we`  out  1  memory write enable.
- `o_mem_addr`  out  32  memory address.
- `o_mem_wdata`  out  32  memory write data.
- `o_mem_sel`  out  4  memory byte enables; `4'hF` for fetches.
- `i_mem_ack`  in  1  memory completion.
- `i_mem_rdata`  in  32  memory read data, valid with `i_mem_ack`.

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register: INST or DATA.
- **IDLE**
  - Request lines are sampled only in this state.
  - If `i_stb_data`: latch the data request, owner = DATA, go to BUSY.
  - Else if `i_stb_inst`: latch the fetch request (`we` = 0, `sel` = F), owner = INST, go to BUSY.
  - Data wins a simultaneous request because it belongs to the older instruction.
- **BUSY**
  - `o_mem_stb` = 1 and all `o_mem_*` outputs are driven from latched values, stable for the whole state.
  - On `i_mem_ack`: capture `i_mem_rdata`, drop `o_mem_stb` next cycle, go to RESP.
- **RESP**
  - The owner's ack is high for exactly one cycle with the captured data. The other ack stays 0.
  - Next state is IDLE unconditionally. A requester stb still high in RESP is the completed request and is ignored.
- Requester rule: stb and payload must be held constant from assertion until ack. Changes made during BUSY have no effect.
- Store responses return `o_rdata` = captured `i_mem_rdata`, which is don't-care to the requester.
- Reset, asynchronous and taking effect at any point including mid-BUSY:
  - State → IDLE; any memory transaction is abandoned.
  - All outputs go to 0: `o_mem_stb`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_sel`, both acks, `o_inst`, `o_rdata`, `o_err`.

## Timing
- Request seen in IDLE at cycle 0 → `o_mem_stb` high at cycle 1.
- Memory ack at cycle N ≥ 1 → requester ack at cycle N+1 → IDLE at N+2.
- Minimum round trip is 2 cycles from request to ack. Peak throughput is one transaction per 3 cycles.
- A back-to-back request from the same requester is accepted the cycle after RESP.
- `i_mem_ack` outside BUSY is ignored.

## Configuration
- `RV32I_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments on each BUSY cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no ack: drop `o_mem_stb`, go to RESP, return data 0 with `o_err` = 1.
  - If ack and timeout coincide, ack wins and `o_err` = 0.
- `RV32I_ARB_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely; `o_err` is tied to 0.

## Test plan
- Fetch only, `i_iaddr` = 0x10, memory acks in the first BUSY cycle with 0x00100093 → `o_mem_stb` high for 1 cycle with addr 0x10 and sel F; `o_ack_inst` 2 cycles after the request with `o_inst` = 0x00100093.
- Simultaneous fetch (0x20) and store (addr 0x100, data 0xDEADBEEF, sel 0x3) → store granted first (`o_mem_we` = 1, sel 3, `o_ack_data`); fetch of 0x20 follows in the next IDLE.
- Memory holds ack low for 5 BUSY cycles on a load of 0x40 → `o_mem_stb` held 6 cycles with a constant address; `o_ack_data` one cycle after the ack; requester address changed mid-BUSY has no effect.
- Reset asserted in BUSY cycle 2 → all outputs 0 immediately; after release, state is IDLE and a new fetch completes normally.
- With `RV32I_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, memory never acks → `o_mem_stb` drops after 4 cycles; `o_ack_inst` = 1 with `o_err` = 1 and `o_inst` = 0. With ack arriving on the 4th cycle → `o_err` = 0 and valid data.
